// File: rtl/bnn_pkg.sv
// Shared constants, frame/score types and read-side states for the BNN frame loader.
package bnn_pkg;

    localparam int PIX_W     = 8;
    localparam int FRAME_W   = 32;
    localparam int N_CLASSES = 4;
    localparam int SCORE_W   = 7;
    localparam int NPIX      = FRAME_W * FRAME_W;
    localparam int CNT_W     = $clog2(NPIX);
    localparam int CLS_W     = $clog2(N_CLASSES);

    typedef logic [0:0][FRAME_W-1:0][FRAME_W-1:0] frame_t;
    typedef logic [N_CLASSES-1:0][SCORE_W-1:0]    scores_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/bnn_argmax.sv
// Combinational argmax over N unsigned scores; ties resolve to the lowest index.
module bnn_argmax #(
    parameter int N = 4,
    parameter int W = 7
) (
    input  logic [N-1:0][W-1:0]   scores,
    output logic [$clog2(N)-1:0]  idx,
    output logic [W-1:0]          score
);

    localparam int IW = $clog2(N);

    always_comb begin
        idx   = '0;
        score = scores[0];
        for (int i = 1; i < N; i++) begin
            if (scores[i] > score) begin
                score = scores[i];
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bnn_frame_loader.sv
// Pixel stream -> ping-pong binary frame banks -> BNN input, then argmax result channel.
//
// state  | meaning
// IDLE   | waiting for the read bank to be full
// SETTLE | frame_o holds the read bank while the BNN settles
// RESULT | argmax registered, res_valid_o high until consumed
module bnn_frame_loader
    import bnn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    pix_valid_i,
    output logic                                    pix_ready_o,
    input  logic [PIX_W-1:0]                        pix_data_i,
    input  logic                                    pix_last_i,
    input  logic [PIX_W-1:0]                        pix_thr_i,
    output logic [0:0][FRAME_W-1:0][FRAME_W-1:0]    frame_o,
    input  logic [N_CLASSES-1:0][SCORE_W-1:0]       scores_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic [CLS_W-1:0]                        res_class_o,
    output logic [SCORE_W-1:0]                      res_score_o,
    output logic                                    err_frame_o
);

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    logic [NPIX-1:0]    bank [2];
    logic [1:0]         full;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [ST_W-1:0]    scnt;
    state_t             state;

    logic               accept;
    logic               pix_bit;
    logic               at_last;
    logic               commit;
    logic               frame_err;
    logic               rel;
    logic               start;
    logic [NPIX-1:0]    merged;
    logic [CLS_W-1:0]   am_idx;
    logic [SCORE_W-1:0] am_score;

    assign pix_ready_o = ~full[wr_ptr];
    assign accept      = pix_valid_i & pix_ready_o;
    assign pix_bit     = (pix_data_i >= pix_thr_i);
    assign at_last     = (cnt == CNT_W'(NPIX - 1));
    assign commit      = accept & pix_last_i & at_last;
    assign frame_err   = accept & (pix_last_i ^ at_last);
    assign rel         = (state == RESULT) & res_ready_i;
    // A commit into the read bank starts SETTLE without waiting for the full flag.
    assign start       = full[rd_ptr] | (commit & (wr_ptr == rd_ptr));

    // Read bank image including the bit landing this cycle.
    always_comb begin
        merged = bank[rd_ptr];
        if (accept && (wr_ptr == rd_ptr)) begin
            merged[cnt] = pix_bit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            bank[wr_ptr][cnt] <= pix_bit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full        <= '0;
            wr_ptr      <= 1'b0;
            cnt         <= '0;
            err_frame_o <= 1'b0;
        end else begin
            err_frame_o <= frame_err;
            if (commit) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
                cnt          <= '0;
            end else if (frame_err) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (rel) begin
                full[rd_ptr] <= 1'b0;
            end
        end
    end

    bnn_argmax #(
        .N (N_CLASSES),
        .W (SCORE_W)
    ) u_argmax (
        .scores (scores_i),
        .idx    (am_idx),
        .score  (am_score)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            scnt        <= '0;
            rd_ptr      <= 1'b0;
            frame_o     <= '0;
            res_valid_o <= 1'b0;
            res_class_o <= '0;
            res_score_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETTLE;
                        scnt    <= ST_W'(SETTLE_CYCLES - 1);
                        frame_o <= merged;
                    end
                end
                SETTLE: begin
                    if (scnt == '0) begin
                        res_class_o <= am_idx;
                        res_score_o <= am_score;
                        res_valid_o <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        scnt <= scnt - ST_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        rd_ptr      <= ~rd_ptr;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Directed and throttled stimulus for bnn_frame_loader with an in-order result scoreboard.
module tb_bnn_frame_loader;
    import bnn_pkg::*;

    logic               clk_i       = 1'b0;
    logic               rst_ni      = 1'b0;
    logic               pix_valid_i = 1'b0;
    logic               pix_last_i  = 1'b0;
    logic               res_ready_i = 1'b0;
    logic [PIX_W-1:0]   pix_data_i  = '0;
    logic [PIX_W-1:0]   pix_thr_i   = '0;
    logic               pix_ready_o;
    logic               res_valid_o;
    logic               err_frame_o;
    frame_t             frame_o;
    scores_t            scores_i;
    logic [CLS_W-1:0]   res_class_o;
    logic [SCORE_W-1:0] res_score_o;

    typedef struct {
        logic [CLS_W-1:0]   cls;
        logic [SCORE_W-1:0] score;
        frame_t             frame;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    logic   fixed_mode = 1'b0;
    frame_t last_frame;
    bit     done5 = 1'b0;

    bnn_frame_loader #(.SETTLE_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .pix_data_i  (pix_data_i),
        .pix_last_i  (pix_last_i),
        .pix_thr_i   (pix_thr_i),
        .frame_o     (frame_o),
        .scores_i    (scores_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_class_o (res_class_o),
        .res_score_o (res_score_o),
        .err_frame_o (err_frame_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in BNN: a fixed score table, or per-class popcount of frame row c.
    function automatic scores_t model_scores(input logic fixed, input frame_t f);
        scores_t s;
        scores_t tab;
        tab = {7'd3, 7'd50, 7'd50, 7'd10};
        for (int c = 0; c < N_CLASSES; c++) begin
            s[c] = fixed ? tab[c] : SCORE_W'($countones(f[0][c]));
        end
        return s;
    endfunction

    function automatic exp_t expect_of(input logic fixed, input frame_t f);
        exp_t    e;
        scores_t s;
        s       = model_scores(fixed, f);
        e.frame = f;
        e.cls   = '0;
        e.score = s[0];
        for (int c = 1; c < N_CLASSES; c++) begin
            if (s[c] > e.score) begin
                e.score = s[c];
                e.cls   = CLS_W'(c);
            end
        end
        return e;
    endfunction

    always_comb scores_i = model_scores(fixed_mode, frame_o);

    task automatic check_frame(input string tag, input frame_t exp_f);
        int bad_row = 0;
        for (int r = FRAME_W - 1; r >= 0; r--) begin
            if (frame_o[0][r] !== exp_f[0][r]) bad_row = r;
        end
        checks++;
        assert (frame_o === exp_f) else begin
            errors++;
            $error("FAIL %s row=%0d observed=%h expected=%h", tag, bad_row,
                   frame_o[0][bad_row[4:0]], exp_f[0][bad_row[4:0]]);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        frame_t zero_f;
        zero_f = '0;
        check_frame({tag, "_frame"}, zero_f);
        check_bit({tag, "_res_valid"}, res_valid_o, 1'b0);
        check_bit({tag, "_err"}, err_frame_o, 1'b0);
        checks++;
        assert (res_class_o === '0 && res_score_o === '0) else begin
            errors++;
            $error("FAIL %s_res observed class=%0d score=%0d expected 0/0", tag, res_class_o, res_score_o);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && res_valid_o && res_ready_i) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result observed class=%0d score=%0d expected none", res_class_o, res_score_o);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert (res_class_o === mon_e.cls) else begin
                    errors++;
                    $error("FAIL res_class observed=%0d expected=%0d", res_class_o, mon_e.cls);
                end
                checks++;
                assert (res_score_o === mon_e.score) else begin
                    errors++;
                    $error("FAIL res_score observed=%0d expected=%0d", res_score_o, mon_e.score);
                end
                check_frame("result_frame", mon_e.frame);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic [7:0] t, input logic l);
        int budget = 5000;
        pix_valid_i = 1'b1;
        pix_data_i  = d;
        pix_thr_i   = t;
        pix_last_i  = l;
        while (!pix_ready_o && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL pix_accept_timeout observed ready=%b expected 1", pix_ready_o);
        end
        tick();
        pix_valid_i = 1'b0;
        pix_last_i  = 1'b0;
    endtask

    // mode 0: pixel n = n%256, thr 128; mode 1: random pixel and threshold.
    task automatic send_frame(input int mode, input int npix, input logic last,
                              input bit throttle, input bit push_en);
        frame_t     f;
        logic [7:0] d;
        logic [7:0] t;
        bit         commit;
        commit = (npix == NPIX) && last;
        f = '0;
        for (int n = 0; n < npix; n++) begin
            if (mode == 0) begin
                d = 8'(n % 256);
                t = 8'd128;
            end else begin
                d = 8'($urandom);
                t = 8'($urandom);
            end
            f[0][n / FRAME_W][n % FRAME_W] = (d >= t);
            if (throttle && $urandom_range(0, 15) == 0) tick();
            if (n == npix - 1) begin
                if (commit && push_en) sb.push_back(expect_of(fixed_mode, f));
                send_pixel(d, t, last);
            end else begin
                send_pixel(d, t, 1'b0);
            end
        end
        last_frame = f;
        if (!commit) begin
            check_bit("err_pulse", err_frame_o, 1'b1);
            tick();
            check_bit("err_pulse_end", err_frame_o, 1'b0);
        end
    endtask

    task automatic wait_drain(input string tag);
        int budget = 3000;
        while ((sb.size() != 0 || res_valid_o) && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL %s_drain_timeout observed pending=%0d expected 0", tag, sb.size());
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check_zero_outputs("reset");
        check_bit("reset_pix_ready", pix_ready_o, 1'b1);
        rst_ni = 1'b1;
        tick();

        // 1: ramp frame, fixed scores, latency and frame_o across SETTLE
        fixed_mode  = 1'b1;
        res_ready_i = 1'b1;
        send_frame(0, NPIX, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_bit("lat_valid_low", res_valid_o, 1'b0);
            check_frame("settle_frame", last_frame);
            tick();
        end
        check_bit("lat_valid_high", res_valid_o, 1'b1);
        wait_drain("t1");

        // 2: two frames with result stalled, third frame blocked
        fixed_mode  = 1'b0;
        res_ready_i = 1'b0;
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b1);
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b1);
        check_bit("both_full_ready", pix_ready_o, 1'b0);
        check_bit("stalled_valid", res_valid_o, 1'b1);
        pix_valid_i = 1'b1;
        pix_data_i  = 8'hff;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("stall_ready", pix_ready_o, 1'b0);
        end
        pix_valid_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check_bit("release_ready", pix_ready_o, 1'b1);
        res_ready_i = 1'b1;
        wait_drain("t2a");
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b1);
        wait_drain("t2b");

        // 3: early last at pixel 500
        send_frame(1, 501, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        check_bit("early_last_no_result", res_valid_o, 1'b0);
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b1);
        wait_drain("t3");

        // 4: missing last at pixel 1023
        send_frame(1, NPIX, 1'b0, 1'b0, 1'b0);
        check_bit("missing_last_ready", pix_ready_o, 1'b1);
        repeat (10) tick();
        check_bit("missing_last_no_result", res_valid_o, 1'b0);
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b1);
        wait_drain("t4");

        // 5: throttled traffic on both channels
        fork
            begin
                for (int fr = 0; fr < 50; fr++) send_frame(1, NPIX, 1'b1, 1'b1, 1'b1);
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    tick();
                    res_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready_i = 1'b1;
        wait_drain("t5");

        // 6: reset during SETTLE, then during RESULT
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b0;
        #1;
        check_zero_outputs("rst_settle");
        tick();
        rst_ni = 1'b1;
        repeat (20) tick();
        check_bit("rst_settle_no_result", res_valid_o, 1'b0);

        res_ready_i = 1'b0;
        send_frame(1, NPIX, 1'b1, 1'b0, 1'b0);
        repeat (6) tick();
        check_bit("result_pending", res_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_zero_outputs("rst_result");
        check_bit("rst_result_ready", pix_ready_o, 1'b1);
        tick();
        rst_ni      = 1'b1;
        res_ready_i = 1'b1;
        repeat (20) tick();
        check_bit("rst_result_no_result", res_valid_o, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
